// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the shared ALU and the arbiter.
// The master side drives requests and the ALU response; the slave side is the arbiter.
// Clock and reset stay outside the bundle as plain ports.
`timescale 1ns/1ps
interface alu_arbiter_if;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        grant0, grant1;
  logic        done0, done1;
  logic [15:0] result0, result1;
  logic        ovf0, ovf1;
  logic        err0, err1;
  logic        busy;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_r;
  logic        alu_overflow;

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_r, alu_overflow,
    input  grant0, grant1, done0, done1, result0, result1,
           ovf0, ovf1, err0, err1, busy, alu_a, alu_b, alu_op
  );

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_r, alu_overflow,
    output grant0, grant1, done0, done1, result0, result1,
           ovf0, ovf1, err0, err1, busy, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two request ports.
// Latency: req sampled at edge N -> grant in cycle N+1 -> done in cycle N+2; one op per 3 cycles.
// Backpressure: requesters hold req until granted; req is ignored while an operation is in flight.
`timescale 1ns/1ps
module alu_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  alu_arbiter_if.slave bus
);

  localparam logic [2:0] OP_ILLEGAL = 3'b011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        last_q;   // port granted most recently
  logic        win_q;    // port owning the operation in flight
  logic        ill_q;    // latched opcode was illegal
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;

  logic        win;
  logic [2:0]  sel_op;
  logic [15:0] sel_a, sel_b;
  logic        sel_ill;

  // Round-robin pick: a lone request wins, a tie goes to the port not granted last.
  always_comb begin
    win = bus.req1;
    if (bus.req0 && bus.req1) win = ~last_q;
  end

  // Operands of the winning port; an illegal opcode is neutralised to OR 0,0.
  always_comb begin
    sel_op  = win ? bus.op1 : bus.op0;
    sel_a   = win ? bus.a1  : bus.a0;
    sel_b   = win ? bus.b1  : bus.b0;
    sel_ill = (sel_op == OP_ILLEGAL);
    if (sel_ill) begin
      sel_op = 3'b000;
      sel_a  = 16'h0000;
      sel_b  = 16'h0000;
    end
  end

  // The ALU only sees operands while executing; otherwise its inputs rest at zero.
  always_comb begin
    bus.alu_op = 3'b000;
    bus.alu_a  = 16'h0000;
    bus.alu_b  = 16'h0000;
    if (state == EXEC) begin
      bus.alu_op = op_q;
      bus.alu_a  = a_q;
      bus.alu_b  = b_q;
    end
  end

  // Controller FSM with registered grant/done/busy and per-port result capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      ill_q       <= 1'b0;
      op_q        <= 3'b000;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      bus.grant0  <= 1'b0;
      bus.grant1  <= 1'b0;
      bus.done0   <= 1'b0;
      bus.done1   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.result0 <= 16'h0000;
      bus.result1 <= 16'h0000;
      bus.ovf0    <= 1'b0;
      bus.ovf1    <= 1'b0;
      bus.err0    <= 1'b0;
      bus.err1    <= 1'b0;
    end else begin
      bus.grant0 <= 1'b0;
      bus.grant1 <= 1'b0;
      bus.done0  <= 1'b0;
      bus.done1  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state    <= EXEC;
            bus.busy <= 1'b1;
            win_q    <= win;
            last_q   <= win;
            ill_q    <= sel_ill;
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            if (win) bus.grant1 <= 1'b1;
            else     bus.grant0 <= 1'b1;
          end
        end
        EXEC: begin
          state <= RESP;
          if (win_q) begin
            bus.result1 <= ill_q ? 16'h0000 : bus.alu_r;
            bus.ovf1    <= ill_q ? 1'b0 : bus.alu_overflow;
            bus.err1    <= ill_q;
            bus.done1   <= 1'b1;
          end else begin
            bus.result0 <= ill_q ? 16'h0000 : bus.alu_r;
            bus.ovf0    <= ill_q ? 1'b0 : bus.alu_overflow;
            bus.err0    <= ill_q;
            bus.done0   <= 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, multi-cycle corner sequences,
// then randomized requesters scored against a transaction-level model.
// The bench also plays the role of the shared combinational ALU.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  alu_arbiter_if bus();

  alu_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  logic [15:0] hr [2];
  logic        ho [2];
  logic        he [2];

  // Shared ALU behaviour; the unused opcode returns garbage so a leak is visible.
  function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    case (op)
      3'b000:  s = {1'b0, a | b};
      3'b001:  s = {1'b0, a & b};
      3'b010:  s = {1'b0, a} + {1'b0, b};
      3'b100:  begin s[15:0] = ~a + 16'd1; s[16] = (a == 16'h8000); end
      3'b101:  s = {1'b0, ~a};
      3'b110:  s = {16'h0000, (a < b)};
      3'b111:  s = {1'b0, a << b[3:0]};
      default: s = 17'h1DEAD;
    endcase
    return s;
  endfunction

  assign {bus.alu_overflow, bus.alu_r} = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_held(input string nm);
    chk({nm, "_result0"}, 32'(bus.result0), 32'(hr[0]));
    chk({nm, "_ovf0"},    32'(bus.ovf0),    32'(ho[0]));
    chk({nm, "_err0"},    32'(bus.err0),    32'(he[0]));
    chk({nm, "_result1"}, 32'(bus.result1), 32'(hr[1]));
    chk({nm, "_ovf1"},    32'(bus.ovf1),    32'(ho[1]));
    chk({nm, "_err1"},    32'(bus.err1),    32'(he[1]));
  endtask

  task automatic drive(input bit p, input logic r, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (p) begin bus.req1 = r; bus.op1 = op; bus.a1 = a; bus.b1 = b; end
    else   begin bus.req0 = r; bus.op0 = op; bus.a0 = a; bus.b0 = b; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin hr[i] = 16'h0; ho[i] = 1'b0; he[i] = 1'b0; end
  endtask

  // One single-port operation from an idle arbiter, checked cycle by cycle.
  task automatic run_op(input bit p, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic eo, input logic ee, input string nm);
    logic ill;
    ill = (op == 3'b011);
    drive(p, 1'b1, op, a, b);
    @(negedge clk);
    chk({nm, "_grant"},       32'(p ? bus.grant1 : bus.grant0), 32'd1);
    chk({nm, "_grant_other"}, 32'(p ? bus.grant0 : bus.grant1), 32'd0);
    chk({nm, "_busy_exec"},   32'(bus.busy), 32'd1);
    chk({nm, "_alu_op"},      32'(bus.alu_op), ill ? 32'd0 : 32'(op));
    chk({nm, "_alu_a"},       32'(bus.alu_a),  ill ? 32'd0 : 32'(a));
    chk({nm, "_alu_b"},       32'(bus.alu_b),  ill ? 32'd0 : 32'(b));
    if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    @(negedge clk);
    chk({nm, "_done"},       32'(p ? bus.done1 : bus.done0), 32'd1);
    chk({nm, "_done_other"}, 32'(p ? bus.done0 : bus.done1), 32'd0);
    chk({nm, "_grant_resp"}, 32'(bus.grant0 | bus.grant1), 32'd0);
    hr[p] = er; ho[p] = eo; he[p] = ee;
    check_held(nm);
    @(negedge clk);
    chk({nm, "_done_gone"}, 32'(bus.done0 | bus.done1), 32'd0);
    chk({nm, "_busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  // Invariants on every cycle: exclusive grant/done, ALU inputs quiet outside execution.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_two_grants", 32'(bus.grant0 & bus.grant1), 32'd0);
      chk("mon_two_dones",  32'(bus.done0 & bus.done1), 32'd0);
      if (!bus.grant0 && !bus.grant1)
        chk("mon_alu_quiet", 32'(|{bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
    end
  end

  typedef struct {
    bit          p;
    logic [2:0]  op;
    logic [15:0] a, b, r;
    logic        o, e;
  } vec_t;

  vec_t vt [12];

  logic g_exp [4];
  logic b_exp [4];
  logic d_exp [4];

  // Random-phase model state.
  bit          gv, dv, gp, dp, last, w;
  logic [15:0] gr, dr;
  logic        go, ge, dov, de;
  int          cool;
  logic [16:0] s;

  initial begin
    vt[0]  = '{1'b0, 3'b010, 16'd50,    16'd100,   16'd150,   1'b0, 1'b0};
    vt[1]  = '{1'b1, 3'b010, 16'd40000, 16'd40000, 16'h3880,  1'b1, 1'b0};
    vt[2]  = '{1'b0, 3'b011, 16'd1234,  16'd5678,  16'h0000,  1'b0, 1'b1};
    vt[3]  = '{1'b1, 3'b000, 16'h00F0,  16'h0F00,  16'h0FF0,  1'b0, 1'b0};
    vt[4]  = '{1'b0, 3'b001, 16'hFF00,  16'h0FF0,  16'h0F00,  1'b0, 1'b0};
    vt[5]  = '{1'b0, 3'b100, 16'h0001,  16'h0000,  16'hFFFF,  1'b0, 1'b0};
    vt[6]  = '{1'b1, 3'b100, 16'h8000,  16'h0000,  16'h8000,  1'b1, 1'b0};
    vt[7]  = '{1'b0, 3'b101, 16'h00FF,  16'h1234,  16'hFF00,  1'b0, 1'b0};
    vt[8]  = '{1'b1, 3'b110, 16'd3,     16'd5,     16'h0001,  1'b0, 1'b0};
    vt[9]  = '{1'b0, 3'b111, 16'h0003,  16'h0004,  16'h0030,  1'b0, 1'b0};
    vt[10] = '{1'b1, 3'b010, 16'hFFFF,  16'h0001,  16'h0000,  1'b1, 1'b0};
    vt[11] = '{1'b1, 3'b011, 16'hAAAA,  16'h5555,  16'h0000,  1'b0, 1'b1};

    // Reset state.
    do_reset();
    mon_en = 1'b1;
    chk("rst_grant", 32'({bus.grant0, bus.grant1}), 32'd0);
    chk("rst_done",  32'({bus.done0, bus.done1}), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    check_held("rst");

    // Directed table.
    for (int i = 0; i < 12; i++)
      run_op(vt[i].p, vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].o, vt[i].e, $sformatf("vec%0d", i));

    // Tie after reset: port 0 first, then port 1, next tie back to port 0.
    do_reset();
    drive(1'b0, 1'b1, 3'b000, 16'h001F, 16'h00F0);
    drive(1'b1, 1'b1, 3'b001, 16'hFFFF, 16'h0001);
    @(negedge clk);
    chk("tie_grant0", 32'(bus.grant0), 32'd1);
    chk("tie_grant1_low", 32'(bus.grant1), 32'd0);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("tie_done0", 32'(bus.done0), 32'd1);
    hr[0] = 16'h00FF;
    check_held("tie_p0");
    @(negedge clk);
    chk("tie_gap_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("tie_grant1", 32'(bus.grant1), 32'd1);
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("tie_done1", 32'(bus.done1), 32'd1);
    hr[1] = 16'h0001;
    check_held("tie_p1");
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 16'd1, 16'd1);
    drive(1'b1, 1'b1, 3'b010, 16'd2, 16'd2);
    @(negedge clk);
    chk("tie2_grant0", 32'(bus.grant0), 32'd1);
    chk("tie2_grant1_low", 32'(bus.grant1), 32'd0);
    bus.req0 = 1'b0;
    @(negedge clk);
    hr[0] = 16'd2;
    check_held("tie2_p0");
    @(negedge clk);
    @(negedge clk);
    chk("tie2_grant1", 32'(bus.grant1), 32'd1);
    bus.req1 = 1'b0;
    @(negedge clk);
    hr[1] = 16'd4;
    check_held("tie2_p1");
    @(negedge clk);

    // Reset during EXEC of a port-1 request, req1 kept high across reset.
    drive(1'b1, 1'b1, 3'b010, 16'd7, 16'd8);
    @(negedge clk);
    chk("abort_grant1", 32'(bus.grant1), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_grant", 32'({bus.grant0, bus.grant1}), 32'd0);
    chk("abort_done",  32'({bus.done0, bus.done1}), 32'd0);
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_alu",   32'(|{bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
    for (int i = 0; i < 2; i++) begin hr[i] = 16'h0; ho[i] = 1'b0; he[i] = 1'b0; end
    check_held("abort");
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_regrant", 32'(bus.grant1), 32'd1);
    chk("abort_no_done", 32'(bus.done1), 32'd0);
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("abort_done1", 32'(bus.done1), 32'd1);
    hr[1] = 16'd15;
    check_held("abort_p1");
    @(negedge clk);

    // Back-to-back with req0 held through two operations.
    g_exp = '{1'b1, 1'b0, 1'b0, 1'b1};
    b_exp = '{1'b1, 1'b1, 1'b0, 1'b1};
    d_exp = '{1'b0, 1'b1, 1'b0, 1'b0};
    drive(1'b0, 1'b1, 3'b010, 16'd1, 16'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_grant0_c%0d", i), 32'(bus.grant0), 32'(g_exp[i]));
      chk($sformatf("b2b_busy_c%0d", i),   32'(bus.busy),   32'(b_exp[i]));
      chk($sformatf("b2b_done0_c%0d", i),  32'(bus.done0),  32'(d_exp[i]));
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("b2b_done0_2", 32'(bus.done0), 32'd1);
    hr[0] = 16'd3;
    check_held("b2b");
    @(negedge clk);

    // Randomized requesters against a transaction-level model.
    do_reset();
    gv = 1'b0; dv = 1'b0; gp = 1'b0; dp = 1'b0; last = 1'b1; cool = 0;
    gr = 16'h0; dr = 16'h0; go = 1'b0; ge = 1'b0; dov = 1'b0; de = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_grant0", 32'(bus.grant0), 32'(gv && !gp));
      chk("rnd_grant1", 32'(bus.grant1), 32'(gv && gp));
      chk("rnd_done0",  32'(bus.done0),  32'(dv && !dp));
      chk("rnd_done1",  32'(bus.done1),  32'(dv && dp));
      if (dv) begin hr[dp] = dr; ho[dp] = dov; he[dp] = de; end
      check_held("rnd");
      // Requesters drop on grant and otherwise raise new work at random.
      for (int p = 0; p < 2; p++) begin
        logic gseen, rnow;
        gseen = (p == 1) ? bus.grant1 : bus.grant0;
        rnow  = (p == 1) ? bus.req1 : bus.req0;
        if (gseen) begin
          if (p == 1) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        end else if (!rnow && $urandom_range(2) == 0) begin
          drive(p[0], 1'b1, 3'($urandom_range(7)),
                ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom),
                ($urandom_range(3) == 0) ? 16'h8000 : 16'($urandom));
        end
      end
      // Grant in this cycle becomes done in the next; one decision per three cycles.
      dv = gv; dp = gp; dr = gr; dov = go; de = ge;
      gv = 1'b0;
      if (cool > 0) cool--;
      else if (bus.req0 || bus.req1) begin
        w = (bus.req0 && bus.req1) ? !last : bus.req1;
        if ((w ? bus.op1 : bus.op0) == 3'b011) begin
          gr = 16'h0; go = 1'b0; ge = 1'b1;
        end else begin
          s = w ? alu_f(bus.op1, bus.a1, bus.b1) : alu_f(bus.op0, bus.a0, bus.b0);
          gr = s[15:0]; go = s[16]; ge = 1'b0;
        end
        gv = 1'b1; gp = w; last = w; cool = 2;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
